// File: rtl/memory_tester_seq_pkg.sv
// Shared definitions for the CPU-bus memory checker: FSM encodings and sizing helpers.
package memory_tester_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILLING = 2'd1,
    ST_PASS    = 2'd2,
    ST_FAIL    = 2'd3
  } state_t;

  localparam int unsigned CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

  // Index width never drops below one bit so a single-entry window still has a port.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/memory_tester_seq.sv
// Memory checker on the CPU data bus: records writes into a small window, compares them
// against an expected image and reports a sticky pass/fail verdict.
//
// state   | meaning
// IDLE    | no write has hit the window since reset
// FILLING | writes arriving, image not yet complete
// PASS    | every entry written with its expected value
// FAIL    | wrong data or order violation seen; held until reset
module memory_tester_seq
  import memory_tester_seq_pkg::*;
#(
  parameter int unsigned              ADDR_SIZE     = 8,
  parameter logic [ADDR_SIZE-1:0]     BASE_ADDR     = 8'h80,
  parameter int unsigned              ARRAY_SIZE    = 4,
  parameter int unsigned              WORD_SIZE     = 8,
  parameter logic [ARRAY_SIZE*WORD_SIZE-1:0] ARRAY_CONTENT = 32'h08060402,
  parameter bit                       ORDERED       = 1'b0,
  parameter int unsigned              READ_LATENCY  = 1,
  localparam int unsigned             IDX_W         = idx_width(ARRAY_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic                 write_en,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 content_ok,
  output logic                 done,
  output logic                 error,
  output logic [CNT_W-1:0]     mismatch_count,
  output logic [IDX_W-1:0]     first_bad_index
);

  localparam int unsigned AXW = ADDR_SIZE + 1;

  state_t state, state_nxt;

  logic [WORD_SIZE-1:0]  mem      [ARRAY_SIZE];
  logic [WORD_SIZE-1:0]  exp_word [ARRAY_SIZE];
  logic [ARRAY_SIZE-1:0] written;
  logic [ARRAY_SIZE-1:0] match;
  logic [IDX_W-1:0]      next_index;
  logic                  order_err_q;
  logic                  bad_seen;
  logic [IDX_W-1:0]      first_bad_q;
  logic [CNT_W-1:0]      mismatch_q;

  logic [AXW-1:0]        addr_x, base_x, limit_x;
  logic                  hit;
  logic [IDX_W-1:0]      idx;
  logic                  wr_hit, data_ok, wrong_wr, order_bad, filling_phase;
  logic [WORD_SIZE-1:0]  rd_word;

  for (genvar g = 0; g < int'(ARRAY_SIZE); g++) begin : g_exp
    assign exp_word[g] = ARRAY_CONTENT[g*WORD_SIZE +: WORD_SIZE];
  end

  assign addr_x  = {1'b0, addr};
  assign base_x  = {1'b0, BASE_ADDR};
  assign limit_x = base_x + AXW'(ARRAY_SIZE);
  assign hit     = (addr_x >= base_x) && (addr_x < limit_x);
  assign idx     = IDX_W'(addr - BASE_ADDR);

  assign wr_hit        = hit && write_en;
  assign data_ok       = (data_in == exp_word[idx]);
  assign wrong_wr      = wr_hit && !data_ok;
  // Rewrites of an already-written entry never count as order violations.
  assign order_bad     = ORDERED && wr_hit && !written[idx] && (idx != next_index);
  assign filling_phase = (state == ST_IDLE) || (state == ST_FILLING);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(ARRAY_SIZE); i++) mem[i] <= '0;
      written     <= '0;
      match       <= '0;
      next_index  <= '0;
      order_err_q <= 1'b0;
      bad_seen    <= 1'b0;
      first_bad_q <= '0;
      mismatch_q  <= '0;
    end else begin
      if (wr_hit) begin
        mem[idx]     <= data_in;
        written[idx] <= 1'b1;
        match[idx]   <= data_ok;
      end
      if (wr_hit && (idx == next_index) && (next_index != IDX_W'(ARRAY_SIZE - 1)))
        next_index <= next_index + 1'b1;
      if (order_bad)
        order_err_q <= 1'b1;
      if (wrong_wr && (mismatch_q != CNT_MAX))
        mismatch_q <= mismatch_q + 1'b1;
      if ((wrong_wr || order_bad) && filling_phase && !bad_seen) begin
        bad_seen    <= 1'b1;
        first_bad_q <= idx;
      end
    end
  end

  assign content_ok = (&written) && (&match);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Decisions in FILLING look at registered post-write flags, so each write
  // takes effect on the verdict one clock later.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (wr_hit) state_nxt = ST_FILLING;
      ST_FILLING: begin
        if (order_err_q)                  state_nxt = ST_FAIL;
        else if ((&written) && !(&match)) state_nxt = ST_FAIL;
        else if (content_ok)              state_nxt = ST_PASS;
      end
      ST_PASS:    if (wrong_wr) state_nxt = ST_FAIL;
      ST_FAIL:    state_nxt = ST_FAIL;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  assign done            = (state == ST_PASS) || (state == ST_FAIL);
  assign error           = (state == ST_FAIL);
  assign mismatch_count  = mismatch_q;
  assign first_bad_index = first_bad_q;

  assign rd_word = hit ? mem[idx] : '0;

  if (READ_LATENCY == 0) begin : g_rd_comb
    assign data_out = rd_word;
  end else begin : g_rd_reg
    logic [WORD_SIZE-1:0] data_out_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) data_out_q <= '0;
      else        data_out_q <= rd_word;
    end
    assign data_out = data_out_q;
  end

endmodule

// File: tb/tb_memory_tester_seq.sv
// Directed bench for memory_tester_seq: three instances (unordered/registered read,
// ordered/registered read, unordered/combinational read) share one stimulus stream.
module tb_memory_tester_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] data_in = 8'h00;
  logic       write_en = 1'b0;

  logic [7:0] a_dout, o_dout, c_dout;
  logic       a_ok, o_ok, c_ok;
  logic       a_done, o_done, c_done;
  logic       a_err, o_err, c_err;
  logic [7:0] a_mm, o_mm, c_mm;
  logic [1:0] a_fb, o_fb, c_fb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  memory_tester_seq #(.ORDERED(1'b0), .READ_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .write_en(write_en),
    .data_out(a_dout), .content_ok(a_ok), .done(a_done), .error(a_err),
    .mismatch_count(a_mm), .first_bad_index(a_fb));

  memory_tester_seq #(.ORDERED(1'b1), .READ_LATENCY(1)) dut_o (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .write_en(write_en),
    .data_out(o_dout), .content_ok(o_ok), .done(o_done), .error(o_err),
    .mismatch_count(o_mm), .first_bad_index(o_fb));

  memory_tester_seq #(.ORDERED(1'b0), .READ_LATENCY(0)) dut_c (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .write_en(write_en),
    .data_out(c_dout), .content_ok(c_ok), .done(c_done), .error(c_err),
    .mismatch_count(c_mm), .first_bad_index(c_fb));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a;
    data_in = d;
    write_en = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic check_zero(input string p);
    chk({p, "_a_ok"}, 32'(a_ok), 0);   chk({p, "_o_ok"}, 32'(o_ok), 0);   chk({p, "_c_ok"}, 32'(c_ok), 0);
    chk({p, "_a_done"}, 32'(a_done), 0); chk({p, "_o_done"}, 32'(o_done), 0); chk({p, "_c_done"}, 32'(c_done), 0);
    chk({p, "_a_err"}, 32'(a_err), 0); chk({p, "_o_err"}, 32'(o_err), 0); chk({p, "_c_err"}, 32'(c_err), 0);
    chk({p, "_a_mm"}, 32'(a_mm), 0);   chk({p, "_o_mm"}, 32'(o_mm), 0);   chk({p, "_c_mm"}, 32'(c_mm), 0);
    chk({p, "_a_fb"}, 32'(a_fb), 0);   chk({p, "_o_fb"}, 32'(o_fb), 0);   chk({p, "_c_fb"}, 32'(c_fb), 0);
    chk({p, "_a_dout"}, 32'(a_dout), 0); chk({p, "_o_dout"}, 32'(o_dout), 0); chk({p, "_c_dout"}, 32'(c_dout), 0);
  endtask

  task automatic check_pass(input string p, input logic [7:0] mm);
    chk({p, "_a_done"}, 32'(a_done), 1); chk({p, "_o_done"}, 32'(o_done), 1); chk({p, "_c_done"}, 32'(c_done), 1);
    chk({p, "_a_err"}, 32'(a_err), 0);   chk({p, "_o_err"}, 32'(o_err), 0);   chk({p, "_c_err"}, 32'(c_err), 0);
    chk({p, "_a_mm"}, 32'(a_mm), 32'(mm)); chk({p, "_o_mm"}, 32'(o_mm), 32'(mm)); chk({p, "_c_mm"}, 32'(c_mm), 32'(mm));
  endtask

  initial begin
    // Reset state
    #1;
    check_zero("rst");
    @(negedge clk);
    reset = 1'b1;

    // Correct fill 02,04,06,08
    wr(8'h80, 8'h02);
    chk("fill_partial_ok", 32'(a_ok), 0);
    chk("fill_partial_done", 32'(a_done), 0);
    wr(8'h81, 8'h04);
    wr(8'h82, 8'h06);
    wr(8'h83, 8'h08);
    chk("fill_a_ok", 32'(a_ok), 1);
    chk("fill_o_ok", 32'(o_ok), 1);
    chk("fill_c_ok", 32'(c_ok), 1);
    chk("fill_done_early", 32'(a_done), 0);
    idle(1);
    check_pass("fill", 8'h00);

    // Reads: combinational same cycle, registered one cycle later
    @(negedge clk);
    addr = 8'h82;
    #1;
    chk("rd82_c_now", 32'(c_dout), 32'h06);
    chk("rd82_a_old", 32'(a_dout), 32'h08);
    @(negedge clk);
    chk("rd82_a_next", 32'(a_dout), 32'h06);
    chk("rd82_o_next", 32'(o_dout), 32'h06);
    addr = 8'h7F;
    #1;
    chk("rd7f_c", 32'(c_dout), 0);
    @(negedge clk);
    chk("rd7f_a", 32'(a_dout), 0);
    addr = 8'h84;
    #1;
    chk("rd84_c", 32'(c_dout), 0);
    @(negedge clk);
    chk("rd84_a", 32'(a_dout), 0);
    addr = 8'h80;
    @(negedge clk);
    chk("rd80_a", 32'(a_dout), 32'h02);

    // PASS: correct rewrite holds, wrong write fails without latching an index
    wr(8'h83, 8'h08);
    chk("pass_rewr_done", 32'(a_done), 1);
    chk("pass_rewr_err", 32'(a_err), 0);
    wr(8'h81, 8'h00);
    chk("pass_bad_err", 32'(a_err), 1);
    chk("pass_bad_mm", 32'(a_mm), 1);
    chk("pass_bad_fb", 32'(a_fb), 0);

    // Wrong data at 81 during fill
    pulse_reset();
    wr(8'h80, 8'h02);
    wr(8'h81, 8'h05);
    chk("bad81_mm", 32'(a_mm), 1);
    chk("bad81_fb", 32'(a_fb), 1);
    wr(8'h82, 8'h06);
    wr(8'h83, 8'h08);
    chk("bad81_done_early", 32'(a_done), 0);
    idle(1);
    chk("bad81_a_err", 32'(a_err), 1);
    chk("bad81_o_err", 32'(o_err), 1);
    chk("bad81_c_err", 32'(c_err), 1);
    chk("bad81_ok", 32'(a_ok), 0);
    wr(8'h83, 8'h04);
    chk("sticky_err", 32'(a_err), 1);
    chk("sticky_mm", 32'(a_mm), 2);
    chk("sticky_fb", 32'(a_fb), 1);

    // Out-of-order: 81 before 80
    pulse_reset();
    wr(8'h81, 8'h04);
    chk("ord_first_err", 32'(o_err), 0);
    wr(8'h80, 8'h02);
    chk("ord_o_err", 32'(o_err), 1);
    chk("ord_o_fb", 32'(o_fb), 1);
    chk("ord_a_err", 32'(a_err), 0);
    wr(8'h82, 8'h06);
    wr(8'h83, 8'h08);
    idle(1);
    chk("ord_a_done", 32'(a_done), 1);
    chk("ord_a_err_end", 32'(a_err), 0);
    chk("ord_a_fb", 32'(a_fb), 0);
    chk("ord_o_err_end", 32'(o_err), 1);
    chk("ord_o_mm", 32'(o_mm), 0);

    // Wrong then corrected 81 before the image is complete
    pulse_reset();
    wr(8'h80, 8'h02);
    wr(8'h81, 8'h07);
    chk("fix_mm", 32'(a_mm), 1);
    wr(8'h81, 8'h04);
    wr(8'h82, 8'h06);
    wr(8'h83, 8'h08);
    idle(1);
    check_pass("fix", 8'h01);
    chk("fix_fb", 32'(a_fb), 1);

    // Saturating mismatch counter
    pulse_reset();
    repeat (255) wr(8'h80, 8'hFF);
    chk("sat255_mm", 32'(a_mm), 255);
    repeat (45) wr(8'h80, 8'hFF);
    chk("sat300_mm", 32'(a_mm), 255);
    chk("sat300_done", 32'(a_done), 0);

    // Async reset mid-fill, then refill
    pulse_reset();
    wr(8'h80, 8'h02);
    wr(8'h81, 8'h09);
    wr(8'h81, 8'h04);
    idle(1);
    chk("mid_pre_dout_a", 32'(a_dout), 32'h04);
    chk("mid_pre_dout_c", 32'(c_dout), 32'h04);
    chk("mid_pre_mm", 32'(a_mm), 1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_zero("midrst");
    @(negedge clk);
    reset = 1'b1;
    wr(8'h80, 8'h02);
    wr(8'h81, 8'h04);
    wr(8'h82, 8'h06);
    wr(8'h83, 8'h08);
    idle(1);
    check_pass("refill", 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
